// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the unified instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned RegBus      = 32;
    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned WdogW       = 8;

    typedef enum logic [2:0] {
        ArbIdle  = 3'd0,
        ArbBusyD = 3'd1,
        ArbBusyI = 3'd2,
        ArbDoneD = 3'd3,
        ArbDoneI = 3'd4
    } arb_state_e;

    typedef enum logic {
        GrantIf  = 1'b0,
        GrantMem = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one ack-handshaked bus, with
// round-robin tie-breaking, a per-transaction watchdog and combinational stall requests.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_ce_i,
    input  logic [InstAddrBus-1:0] if_addr_i,
    output logic [RegBus-1:0]      if_data_o,
    output logic                   if_stallreq_o,
    input  logic                   mem_ce_i,
    input  logic                   mem_we_i,
    input  logic [3:0]             mem_sel_i,
    input  logic [RegBus-1:0]      mem_addr_i,
    input  logic [RegBus-1:0]      mem_data_i,
    output logic [RegBus-1:0]      mem_data_o,
    output logic                   mem_stallreq_o,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [3:0]             bus_sel_o,
    output logic [RegBus-1:0]      bus_addr_o,
    output logic [RegBus-1:0]      bus_data_o,
    input  logic [RegBus-1:0]      bus_data_i,
    input  logic                   bus_ack_i,
    output logic                   bus_err_o
);

    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    grant_e            last_q, last_d;
    logic [WdogW-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [RegBus-1:0] addr_q, addr_d;
    logic [RegBus-1:0] wdata_q, wdata_d;
    logic [RegBus-1:0] if_data_q, if_data_d;
    logic [RegBus-1:0] mem_data_q, mem_data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ArbIdle;
            last_q     <= GrantIf;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        case (state_q)
            ArbIdle: begin
                // Data wins a tie unless it was the last port served.
                if (mem_ce_i && (!if_ce_i || last_q == GrantIf)) begin
                    state_d = ArbBusyD;
                    cnt_d   = '0;
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_data_i;
                end else if (if_ce_i) begin
                    state_d = ArbBusyI;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                end
            end
            ArbBusyD, ArbBusyI: begin
                if (bus_ack_i) begin
                    if (state_q == ArbBusyD) begin
                        if (!we_q) mem_data_d = bus_data_i;
                        last_d  = GrantMem;
                        state_d = ArbDoneD;
                    end else begin
                        if_data_d = bus_data_i;
                        last_d    = GrantIf;
                        state_d   = ArbDoneI;
                    end
                end else if (cnt_q == WdogLast) begin
                    err_d = 1'b1;
                    if (state_q == ArbBusyD) begin
                        mem_data_d = '0;
                        state_d    = ArbDoneD;
                    end else begin
                        if_data_d = '0;
                        state_d   = ArbDoneI;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ArbDoneD, ArbDoneI: state_d = ArbIdle;
            default:            state_d = ArbIdle;
        endcase
    end

    assign bus_req_o  = (state_q == ArbBusyD) || (state_q == ArbBusyI);
    assign bus_we_o   = we_q;
    assign bus_sel_o  = sel_q;
    assign bus_addr_o = addr_q;
    assign bus_data_o = wdata_q;
    assign bus_err_o  = err_q;
    assign if_data_o  = if_data_q;
    assign mem_data_o = mem_data_q;

    assign if_stallreq_o  = rst & if_ce_i & (state_q != ArbDoneI);
    assign mem_stallreq_o = rst & mem_ce_i & (state_q != ArbDoneD);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration, latency and data return.
module tb_mem_bus_arbiter;

    localparam int unsigned TOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_ce = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_stall;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_data;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err;

    int checks = 0;
    int passes = 0;

    // Transaction-level model state
    bit          m_last_mem = 1'b0;
    logic [31:0] exp_if = '0;
    logic [31:0] exp_mem = '0;

    mem_bus_arbiter #(.TIMEOUT(TOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (if_ce),
        .if_addr_i      (if_addr),
        .if_data_o      (if_data),
        .if_stallreq_o  (if_stall),
        .mem_ce_i       (mem_ce),
        .mem_we_i       (mem_we),
        .mem_sel_i      (mem_sel),
        .mem_addr_i     (mem_addr),
        .mem_data_i     (mem_wdata),
        .mem_data_o     (mem_data),
        .mem_stallreq_o (mem_stall),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_sel_o      (bus_sel),
        .bus_addr_o     (bus_addr),
        .bus_data_o     (bus_wdata),
        .bus_data_i     (bus_rdata),
        .bus_ack_i      (bus_ack),
        .bus_err_o      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus_req); else passes++;
        checks++; if (bus_sel !== 4'h0) $display("FAIL rst_sel got %h exp 0", bus_sel); else passes++;
        checks++; if ({if_data, mem_data, bus_addr, bus_wdata} !== 128'h0)
            $display("FAIL rst_data got %h exp 0", {if_data, mem_data, bus_addr, bus_wdata}); else passes++;
        checks++; if ({bus_we, bus_err, if_stall, mem_stall} !== 4'b0)
            $display("FAIL rst_flags got %b exp 0000", {bus_we, bus_err, if_stall, mem_stall}); else passes++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        if_addr = 32'h0000_0100; if_ce = 1'b1; #1;
        checks++; if (if_stall !== 1'b1) $display("FAIL fetch_stall_c0 got %b exp 1", if_stall); else passes++;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h3C01_1234; #1;
        checks++; if (if_stall !== 1'b1) $display("FAIL fetch_stall_c1 got %b exp 1", if_stall); else passes++;
        checks++; if (bus_req !== 1'b1) $display("FAIL fetch_req got %b exp 1", bus_req); else passes++;
        checks++; if (bus_addr !== 32'h100) $display("FAIL fetch_addr got %h exp 100", bus_addr); else passes++;
        tick();
        bus_ack = 1'b0;
        exp_if = 32'h3C01_1234; m_last_mem = 1'b0;
        checks++; if (if_stall !== 1'b0) $display("FAIL fetch_stall_c2 got %b exp 0", if_stall); else passes++;
        checks++; if (if_data !== exp_if) $display("FAIL fetch_data got %h exp %h", if_data, exp_if); else passes++;
        checks++; if (bus_req !== 1'b0) $display("FAIL fetch_req_done got %b exp 0", bus_req); else passes++;
        if_ce = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] rd;
        bit          win_mem;
        if_addr = 32'h200; if_ce = 1'b1;
        mem_addr = 32'h8000_0010; mem_we = 1'b0; mem_sel = 4'hF; mem_ce = 1'b1;
        for (int n = 0; n < 4; n++) begin
            win_mem = !m_last_mem;
            tick();
            rd = $urandom; bus_rdata = rd; bus_ack = 1'b1;
            checks++; if (bus_addr !== (win_mem ? 32'h8000_0010 : 32'h200))
                $display("FAIL sim_grant%0d got %h exp_mem %b", n, bus_addr, win_mem); else passes++;
            if (n == 0) begin
                checks++; if (bus_we !== 1'b0) $display("FAIL sim_we got %b exp 0", bus_we); else passes++;
            end
            tick();
            bus_ack = 1'b0;
            if (win_mem) exp_mem = rd; else exp_if = rd;
            m_last_mem = win_mem;
            checks++; if ({if_stall, mem_stall} !== {win_mem, !win_mem})
                $display("FAIL sim_stall%0d got %b exp %b", n, {if_stall, mem_stall}, {win_mem, !win_mem});
            else passes++;
            checks++; if ((win_mem ? mem_data : if_data) !== rd)
                $display("FAIL sim_data%0d got %h exp %h", n, win_mem ? mem_data : if_data, rd); else passes++;
            tick();
        end
        if_ce = 1'b0; mem_ce = 1'b0;
    endtask

    task automatic test_store();
        bit ok = 1'b1;
        mem_we = 1'b1; mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF; mem_addr = 32'h40; mem_ce = 1'b1;
        #1;
        checks++; if (mem_stall !== 1'b1) $display("FAIL store_stall_c0 got %b exp 1", mem_stall); else passes++;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) begin bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF; end
            if (!(bus_req === 1'b1 && bus_we === 1'b1 && bus_sel === 4'b0011 &&
                  bus_addr === 32'h40 && bus_wdata === 32'hDEAD_BEEF && mem_stall === 1'b1))
                ok = 1'b0;
        end
        checks++; if (!ok) $display("FAIL store_fields got unstable exp stable"); else passes++;
        tick();
        bus_ack = 1'b0; m_last_mem = 1'b1;
        checks++; if (mem_stall !== 1'b0) $display("FAIL store_stall_c6 got %b exp 0", mem_stall); else passes++;
        checks++; if (mem_data !== exp_mem) $display("FAIL store_data got %h exp %h", mem_data, exp_mem); else passes++;
        mem_ce = 1'b0; mem_we = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok = 1'b1;
        if_addr = 32'h300; if_ce = 1'b1;
        for (int k = 1; k <= int'(TOUT); k++) begin
            tick();
            if (!(bus_req === 1'b1 && bus_err === 1'b0 && if_stall === 1'b1)) ok = 1'b0;
        end
        checks++; if (!ok) $display("FAIL tout_busy got early end exp %0d busy cycles", TOUT); else passes++;
        tick();
        exp_if = '0;
        checks++; if (bus_err !== 1'b1) $display("FAIL tout_err got %b exp 1", bus_err); else passes++;
        checks++; if (if_data !== exp_if) $display("FAIL tout_data got %h exp 0", if_data); else passes++;
        checks++; if (if_stall !== 1'b0) $display("FAIL tout_stall got %b exp 0", if_stall); else passes++;
        if_ce = 1'b0;
        tick();
        checks++; if ({bus_err, bus_req} !== 2'b00) $display("FAIL tout_idle got %b exp 00", {bus_err, bus_req});
        else passes++;
    endtask

    task automatic test_ack_timeout_coincide();
        if_addr = 32'h304; if_ce = 1'b1;
        for (int k = 1; k <= int'(TOUT); k++) begin
            tick();
            if (k == int'(TOUT)) begin bus_ack = 1'b1; bus_rdata = 32'h1234_5678; end
        end
        tick();
        bus_ack = 1'b0; exp_if = 32'h1234_5678; m_last_mem = 1'b0;
        checks++; if (bus_err !== 1'b0) $display("FAIL coin_err got %b exp 0", bus_err); else passes++;
        checks++; if (if_data !== exp_if) $display("FAIL coin_data got %h exp %h", if_data, exp_if); else passes++;
        if_ce = 1'b0;
        tick();
    endtask

    task automatic test_ce_drop();
        mem_addr = 32'h88; mem_we = 1'b0; mem_sel = 4'hF; mem_ce = 1'b1;
        tick();
        mem_ce = 1'b0; #1;
        checks++; if (mem_stall !== 1'b0) $display("FAIL drop_stall got %b exp 0", mem_stall); else passes++;
        tick();
        checks++; if (bus_req !== 1'b1) $display("FAIL drop_req got %b exp 1", bus_req); else passes++;
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001;
        tick();
        bus_ack = 1'b0; m_last_mem = 1'b1;
        checks++; if ({bus_req, mem_stall, bus_err} !== 3'b000)
            $display("FAIL drop_done got %b exp 000", {bus_req, mem_stall, bus_err}); else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        mem_addr = 32'h90; mem_we = 1'b0; mem_sel = 4'hF; mem_ce = 1'b1;
        tick();
        checks++; if (bus_req !== 1'b1) $display("FAIL rmid_busy got %b exp 1", bus_req); else passes++;
        rst = 1'b0; #1;
        checks++; if (bus_req !== 1'b0) $display("FAIL rmid_req got %b exp 0", bus_req); else passes++;
        checks++; if ({if_data, mem_data, bus_addr, bus_wdata} !== 128'h0)
            $display("FAIL rmid_data got %h exp 0", {if_data, mem_data, bus_addr, bus_wdata}); else passes++;
        checks++; if ({bus_sel, bus_we, bus_err, mem_stall} !== 7'b0)
            $display("FAIL rmid_flags got %b exp 0", {bus_sel, bus_we, bus_err, mem_stall}); else passes++;
        mem_ce = 1'b0;
        exp_if = '0; exp_mem = '0; m_last_mem = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit          win_mem, acked, exp_we;
        int          waits;
        logic [31:0] rd, exp_addr;
        for (int t = 0; t < 40; t++) begin
            if (!if_ce && $urandom_range(0, 1) == 1) begin if_ce = 1'b1; if_addr = $urandom; end
            if (!mem_ce && $urandom_range(0, 1) == 1) begin
                mem_ce = 1'b1; mem_addr = $urandom; mem_wdata = $urandom;
                mem_we = 1'($urandom_range(0, 1)); mem_sel = 4'($urandom);
            end
            if (!if_ce && !mem_ce) begin if_ce = 1'b1; if_addr = $urandom; end
            win_mem  = mem_ce && (!if_ce || !m_last_mem);
            exp_addr = win_mem ? mem_addr : if_addr;
            exp_we   = win_mem ? mem_we : 1'b0;
            #1;
            checks++; if ({if_stall, mem_stall} !== {if_ce, mem_ce})
                $display("FAIL rnd_req_stall%0d got %b exp %b", t, {if_stall, mem_stall}, {if_ce, mem_ce});
            else passes++;
            waits = $urandom_range(0, 9);
            acked = 1'b0;
            rd    = $urandom;
            for (int k = 1; k <= int'(TOUT); k++) begin
                tick();
                if (k == 1) begin
                    checks++; if ({bus_req, bus_we, bus_addr} !== {1'b1, exp_we, exp_addr})
                        $display("FAIL rnd_bus%0d got %b/%b/%h exp 1/%b/%h",
                                 t, bus_req, bus_we, bus_addr, exp_we, exp_addr);
                    else passes++;
                end
                if (k == waits + 1) begin bus_ack = 1'b1; bus_rdata = rd; acked = 1'b1; end
                if (acked) break;
            end
            tick();
            bus_ack = 1'b0;
            if (acked) begin
                m_last_mem = win_mem;
                if (!win_mem) exp_if = rd;
                else if (!exp_we) exp_mem = rd;
            end else if (win_mem) exp_mem = '0;
            else exp_if = '0;
            checks++; if (bus_err !== !acked) $display("FAIL rnd_err%0d got %b exp %b", t, bus_err, !acked);
            else passes++;
            checks++; if ({if_data, mem_data} !== {exp_if, exp_mem})
                $display("FAIL rnd_data%0d got %h/%h exp %h/%h", t, if_data, mem_data, exp_if, exp_mem);
            else passes++;
            checks++; if ({bus_req, if_stall, mem_stall} !== {1'b0, if_ce & win_mem, mem_ce & !win_mem})
                $display("FAIL rnd_done%0d got %b exp %b", t, {bus_req, if_stall, mem_stall},
                         {1'b0, if_ce & win_mem, mem_ce & !win_mem});
            else passes++;
            if (win_mem) mem_ce = 1'b0; else if_ce = 1'b0;
            tick();
        end
        if_ce = 1'b0; mem_ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_timeout();
        test_ack_timeout_coincide();
        test_ce_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-ported, ack-handshaked memory bus between the CPU's instruction-fetch port (pc_reg/if_id side) and data port (mem stage side). It replaces the separate rom/ram paths of the openmips core with a unified memory. It serialises requests, holds each transaction on the bus until `bus_ack_i`, and returns read data to the requesting stage. It raises per-port stall requests toward `ctrl` while an access is outstanding.

## Interface
- `TIMEOUT`, default 255: busy cycles without ack before abort, 1..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_ce_i` in 1: fetch request, held by IF until served.
- `if_addr_i` in 32: fetch address.
- `if_data_o` out 32: fetched instruction, valid while `if_stallreq_o`=0 and `if_ce_i`=1.
- `if_stallreq_o` out 1: fetch not yet served.
- `mem_ce_i` in 1: data request.
- `mem_we_i` in 1: 1 = store.
- `mem_sel_i` in 4: byte enables.
- `mem_addr_i` in 32: data address.
- `mem_data_i` in 32: store data.
- `mem_data_o` out 32: load data.
- `mem_stallreq_o` out 1: data access not yet served.
- `bus_req_o` out 1: transaction active.
- `bus_we_o`, `bus_sel_o`[4], `bus_addr_o`[32], `bus_data_o`[32] out: registered transaction fields.
- `bus_data_i` in 32: read data.
- `bus_ack_i` in 1: completes the current transaction.
- `bus_err_o` out 1: one-cycle pulse on timeout abort.

## Operation
- FSM states:
  - IDLE: no transaction.
  - BUSY_D / BUSY_I: data / fetch transaction on the bus.
  - DONE_D / DONE_I: one-cycle result slot.
- IDLE:
  - If either ce is high, pick a winner, register its fields onto the bus, enter BUSY_x.
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins. `last_grant` resets to IF, so data wins the first tie.
- BUSY_x:
  - `bus_req_o`=1; fields stay stable.
  - Watchdog counter increments each cycle.
  - On `bus_ack_i`=1: capture `bus_data_i` into that port's data register (reads only; stores leave it unchanged), update `last_grant`, enter DONE_x.
  - If the counter reaches TIMEOUT before ack: data register becomes 0, `bus_err_o` pulses, enter DONE_x.
- DONE_x: `bus_req_o`=0. Next state is always IDLE.
- Stall requests:
  - `if_stallreq_o` = `if_ce_i` & ~(state==DONE_I).
  - `mem_stallreq_o` = `mem_ce_i` & ~(state==DONE_D).
  - Both are forced to 0 while `rst`=0.
- A request still asserted in the cycle after DONE_x is a new request and is re-arbitrated. Re-fetch is harmless; the mem stage never holds a completed store, because the pipeline advances during DONE_D.
- ce dropped during BUSY_x: the transaction still runs to ack or timeout and the result is discarded. No abort is ever driven on the bus.
- Output data registers hold their value until the next capture for that port.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE, `last_grant`=IF, watchdog 0.
  - `bus_req_o`, `bus_we_o`, `bus_err_o` = 0.
  - `bus_sel_o`=4'h0; `bus_addr_o`, `bus_data_o`, `if_data_o`, `mem_data_o` = 0.
  - Reset mid-transaction drops `bus_req_o` immediately.
- Access with ack in the first BUSY cycle:
  - cycle 0: request seen in IDLE, stallreq=1.
  - cycle 1: BUSY, `bus_req_o`=1, ack.
  - cycle 2: DONE, stallreq=0, data valid.
  - Minimum access latency is 3 cycles; bus throughput is one access per 3 cycles.
- Each ack-wait cycle adds one cycle. Timeout abort ends in DONE after TIMEOUT BUSY cycles.
- `bus_ack_i` is sampled only in BUSY states and ignored elsewhere.
- Ack and timeout in the same cycle: ack wins, no error.
- Stall requests are combinational from ce and state, with no register delay. `ctrl` sees them in the same cycle.

## Structure
- Add to `defines.v`:
  - State encodings: `ArbIdle`, `ArbBusyD`, `ArbBusyI`, `ArbDoneD`, `ArbDoneI`, 3 bits.
  - Grant constants: `GrantIf`, `GrantMem`.
  - Reuse `RegBus` / `InstAddrBus` for widths.
- Single module; no sub-module. The watchdog counter and round-robin bit are inline.
- `openmips` top gains `stallreq_from_if` into `ctrl`, and `mem_stallreq_o` is routed into `ctrl`'s mem-stage stall input.

## Test plan
- Reset and single fetch: release `rst`, `if_ce_i`=1, addr 0x0000_0100, ack in BUSY cycle 1 with 0x3C01_1234.
  - `if_stallreq_o` is 1,1,0; `if_data_o`=0x3C01_1234 in cycle 2; `bus_addr_o`=0x100.
- Simultaneous requests: IF 0x200 and load 0x8000_0010, ack immediate.
  - Data is granted first (`bus_we_o`=0).
  - Both ce still held in cycle 3: IF granted next.
  - With both held continuously, grants alternate D, I, D, I.
- Store: `mem_we_i`=1, sel 4'b0011, data 0xDEAD_BEEF, ack after 4 wait cycles.
  - Bus fields stable for 5 BUSY cycles; `mem_stallreq_o` drops in cycle 6; `mem_data_o` unchanged.
- Timeout: TIMEOUT=8, no ack.
  - `bus_err_o` pulses after 8 BUSY cycles; `if_data_o`=0; FSM returns to IDLE.
- Ack and timeout coincide at cycle TIMEOUT: data is captured and `bus_err_o`=0.
- Mid-operation edge cases:
  - `rst` asserted in BUSY_D: `bus_req_o` drops to 0 without a clock edge, and all outputs return to reset values.
  - `mem_ce_i` dropped in BUSY: the transaction still completes on ack and no stall is reported.
